sop_edge_counter: RTL and testbench

//  Downstream consumer of the AND-OR (sum-of-products) stage output Y.

---
 rtl/sop_edge_counter_pkg.sv | 20 ++
 rtl/sop_edge_counter_sync_2ff.sv | 25 ++
 rtl/sop_edge_counter.sv | 139 +++++++++++++
 tb/tb_sop_edge_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sop_edge_counter_pkg.sv
// Shared definitions for the sum-of-products edge counter and later stages
// that consume the same debounced Y signal.
package sop_edge_counter_pkg;

  // Debounce FSM states. The encodings are fixed so that the display/check
  // logic can decode the state bits directly.
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } dbnc_state_e;

  // Width of the stable-sample counter. It only ever holds values from
  // 0 to stable_cycles-1, so clog2 of the cycle count is always enough.
  function automatic int dcnt_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage : sop_edge_counter_pkg

// File: rtl/sop_edge_counter_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit. It resets to 0 and is
// shared with the later stages that also sample Y.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let both flops sample their inputs on
      // the same edge; blocking ones would collapse the chain into one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/sop_edge_counter.sv
// Consumer of the AND-OR stage output Y: synchronises it, debounces it with
// a four-state FSM, emits one pulse per accepted rising edge and counts the
// edges, with sticky threshold and overflow flags for the display logic.
module sop_edge_counter
  import sop_edge_counter_pkg::*;
#(
  parameter int CNT_W         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int THRESH        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             en,
  input  logic             clr,
  output logic             y_clean,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] count,
  output logic             thresh_hit,
  output logic             overflow
);

  localparam int                DCNT_W    = dcnt_width(STABLE_CYCLES);
  // A level is accepted on the sample that finds dcnt at its last value,
  // which makes STABLE_CYCLES consecutive samples including the first.
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(STABLE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [CNT_W-1:0]  THRESH_V  = CNT_W'(THRESH);

  logic              y_s;
  dbnc_state_e       state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              y_clean_d;
  logic              rise_d;
  logic [CNT_W-1:0]  cnt_inc;

  // Bring the asynchronous Y into the clk domain; the FSM sees only y_s.
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (y_in),
    .q     (y_s)
  );

  // Debounce next-state logic: any disagreeing sample during a pending
  // transition sends the FSM back to the settled level it came from.
  always_comb begin
    // NOTE: every variable gets a default first so that no path through the
    // case below leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    y_clean_d = y_clean;
    rise_d    = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (y_s) begin
          state_d = S_RISE;
          dcnt_d  = DCNT_ONE;
        end
      end
      S_RISE: begin
        if (!y_s) begin
          state_d = S_LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = S_HIGH;
          dcnt_d    = '0;
          y_clean_d = 1'b1;
          rise_d    = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      S_HIGH: begin
        if (!y_s) begin
          state_d = S_FALL;
          dcnt_d  = DCNT_ONE;
        end
      end
      S_FALL: begin
        if (y_s) begin
          state_d = S_HIGH;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = S_LOW;
          dcnt_d    = '0;
          y_clean_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        dcnt_d  = '0;
      end
    endcase
  end

  // Debounce state register; y_clean and rise_pulse are registered here so
  // no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOW;
      dcnt_q     <= '0;
      y_clean    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      y_clean    <= y_clean_d;
      rise_pulse <= rise_d;
    end
  end

  assign cnt_inc = count + CNT_W'(1);

  // Event counter with sticky flags; clear wins over a coincident pulse,
  // and the pulse is only counted while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      thresh_hit <= 1'b0;
      overflow   <= 1'b0;
    end else if (clr) begin
      count      <= '0;
      thresh_hit <= 1'b0;
      overflow   <= 1'b0;
    end else if (rise_pulse && en) begin
      count <= cnt_inc;
      if (count == '1) begin
        overflow <= 1'b1;
      end
      if (cnt_inc == THRESH_V) begin
        thresh_hit <= 1'b1;
      end
    end
  end

endmodule : sop_edge_counter

// File: tb/tb_sop_edge_counter.sv
// Directed bench for sop_edge_counter with CNT_W=4, STABLE_CYCLES=4,
// THRESH=3. y_in comes from a small AND-OR expression driven by a and b.
module tb_sop_edge_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       y_in;
  logic       y_clean, rise_pulse, thresh_hit, overflow;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  // AND-OR stage feeding the counter.
  assign y_in = (a & b) | (c & d);

  always #5 clk = ~clk;

  sop_edge_counter #(
    .CNT_W         (4),
    .STABLE_CYCLES (4),
    .THRESH        (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y_in       (y_in),
    .en         (en),
    .clr        (clr),
    .y_clean    (y_clean),
    .rise_pulse (rise_pulse),
    .count      (count),
    .thresh_hit (thresh_hit),
    .overflow   (overflow)
  );

  // One row: level of Y and controls held for reps cycles, and the outputs
  // expected after every one of those edges.
  typedef struct {
    logic       y;
    logic       en;
    logic       clr;
    int         reps;
    logic       yc;
    logic       rp;
    logic [3:0] cnt;
    logic       th;
    logic       ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {y_clean, rise_pulse, count, thresh_hit, overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full clean high/low excursion of Y; checks the pulse timing and
  // optionally asserts clr on the cycle the pulse is high.
  task automatic do_pulse(input logic en_v, input logic clr_v, input string name);
    en = en_v;
    a  = 1'b1;
    b  = 1'b1;
    repeat (5) tick();
    check({name, " pre-accept y_clean"}, 32'(y_clean), 32'd0);
    tick();
    check({name, " rise_pulse"}, 32'({y_clean, rise_pulse}), 32'b11);
    clr = clr_v;
    tick();
    clr = 1'b0;
    check({name, " pulse one cycle"}, 32'(rise_pulse), 32'd0);
    a = 1'b0;
    repeat (6) tick();
    check({name, " fall y_clean"}, 32'(y_clean), 32'd0);
    en = 1'b1;
  endtask

  initial begin
    // Clean rise: accept after edge 5, count follows one cycle later.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    // Low glitch of 3 samples while high is ignored.
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    // Clean fall: y_clean drops after edge 5, no pulse.
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    // High glitch of 3 samples while low is ignored.
    vecs[7] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};

    // Reset held with Y toggling: every output stays 0.
    rst_n = 1'b0;
    b     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = ~a;
      tick();
      check($sformatf("reset outs %0d", i), 32'(outs()), 32'd0);
    end
    a = 1'b0;
    b = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle after reset", 32'(outs()), 32'd0);

    // Table-driven clean edges and glitches.
    for (int v = 0; v < 9; v++) begin
      a   = vecs[v].y;
      b   = vecs[v].y;
      en  = vecs[v].en;
      clr = vecs[v].clr;
      for (int r = 0; r < vecs[v].reps; r++) begin
        tick();
        check($sformatf("vec %0d cyc %0d", v, r), 32'(outs()),
              32'({vecs[v].yc, vecs[v].rp, vecs[v].cnt, vecs[v].th, vecs[v].ov}));
      end
    end
    clr = 1'b0;
    en  = 1'b1;

    // Threshold: count 1 -> 2 (no flag) -> 3 (flag set).
    do_pulse(1'b1, 1'b0, "p2");
    check("count 2 no thresh", 32'({count, thresh_hit, overflow}), 32'({4'd2, 1'b0, 1'b0}));
    do_pulse(1'b1, 1'b0, "p3");
    check("count 3 thresh", 32'({count, thresh_hit, overflow}), 32'({4'd3, 1'b1, 1'b0}));

    // Up to all-ones without overflow, then wrap.
    for (int i = 0; i < 12; i++) do_pulse(1'b1, 1'b0, "pw");
    check("count 15", 32'({count, thresh_hit, overflow}), 32'({4'd15, 1'b1, 1'b0}));
    do_pulse(1'b1, 1'b0, "pwrap");
    check("wrap overflow", 32'({count, thresh_hit, overflow}), 32'({4'd0, 1'b1, 1'b1}));

    // clr on the pulse cycle: flags clear and the event is dropped.
    do_pulse(1'b1, 1'b1, "pclr");
    check("clr drops event", 32'({count, thresh_hit, overflow}), 32'd0);
    do_pulse(1'b1, 1'b0, "pafter");
    check("count after clr", 32'(count), 32'd1);

    // en=0: pulses still appear (checked in do_pulse), count holds.
    do_pulse(1'b0, 1'b0, "pdis0");
    do_pulse(1'b0, 1'b0, "pdis1");
    check("en=0 holds", 32'({count, thresh_hit, overflow}), 32'({4'd1, 1'b0, 1'b0}));
    do_pulse(1'b1, 1'b0, "pen");
    check("en=1 counts", 32'(count), 32'd2);

    // Mid-operation reset while in S_RISE with dcnt=2.
    a = 1'b1;
    b = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset mid-op", 32'(outs()), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("post-reset rise %0d", k), 32'({y_clean, rise_pulse, count}),
            32'({k >= 5 ? 1'b1 : 1'b0, k == 5 ? 1'b1 : 1'b0, k >= 6 ? 4'd1 : 4'd0}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sop_edge_counter
